// File: rtl/neural_pixel_packer.sv
// Packs four (current, previous, mask) pixel triples into 32-bit rs1/rs2/mask words for the
// 4-lane neural SIMD datapath. A completed word that finds the output slot busy waits in the
// assembly register, and input is back-pressured until it moves out.
module neural_pixel_packer #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [7:0]  PAD_PIX = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_cur,
  input  logic [7:0]       in_prev,
  input  logic             in_last,
  input  logic [7:0]       cfg_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      rs1,
  output logic [31:0]      rs2,
  output logic [31:0]      mask,
  output logic             out_last,
  output logic [2:0]       out_lanes,
  output logic [CNT_W-1:0] word_count
);

  logic [1:0]       lane_idx_q, lane_idx_d;
  logic [31:0]      asm_rs1_q, asm_rs1_d;
  logic [31:0]      asm_rs2_q, asm_rs2_d;
  logic [31:0]      asm_mask_q, asm_mask_d;
  logic             asm_full_q, asm_full_d;
  logic             asm_last_q, asm_last_d;
  logic [2:0]       asm_lanes_q, asm_lanes_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      mask_q, mask_d;
  logic             out_last_q, out_last_d;
  logic [2:0]       out_lanes_q, out_lanes_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic             accept;
  logic             slot_free;
  logic             complete;
  logic [2:0]       fill_lanes;
  // wr_*: assembly contents with the incoming pixel written; cw_*: same, upper lanes padded
  logic [31:0]      wr_rs1, wr_rs2, wr_mask;
  logic [31:0]      cw_rs1, cw_rs2, cw_mask;

  always_comb begin
    accept     = in_valid && !asm_full_q;
    slot_free  = !out_valid_q || out_ready;
    complete   = accept && ((lane_idx_q == 2'd3) || in_last);
    fill_lanes = {1'b0, lane_idx_q} + 3'd1;

    wr_rs1  = asm_rs1_q;
    wr_rs2  = asm_rs2_q;
    wr_mask = asm_mask_q;
    cw_rs1  = asm_rs1_q;
    cw_rs2  = asm_rs2_q;
    cw_mask = asm_mask_q;
    for (int k = 0; k < 4; k++) begin
      if (k == int'(lane_idx_q)) begin
        wr_rs1[8*k +: 8]  = in_cur;
        wr_rs2[8*k +: 8]  = in_prev;
        wr_mask[8*k +: 8] = cfg_mask;
        cw_rs1[8*k +: 8]  = in_cur;
        cw_rs2[8*k +: 8]  = in_prev;
        cw_mask[8*k +: 8] = cfg_mask;
      end else if (k > int'(lane_idx_q)) begin
        cw_rs1[8*k +: 8]  = PAD_PIX;
        cw_rs2[8*k +: 8]  = PAD_PIX;
        cw_mask[8*k +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    lane_idx_d   = lane_idx_q;
    asm_rs1_d    = asm_rs1_q;
    asm_rs2_d    = asm_rs2_q;
    asm_mask_d   = asm_mask_q;
    asm_full_d   = asm_full_q;
    asm_last_d   = asm_last_q;
    asm_lanes_d  = asm_lanes_q;
    out_valid_d  = out_valid_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    mask_d       = mask_q;
    out_last_d   = out_last_q;
    out_lanes_d  = out_lanes_q;
    word_count_d = word_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + CNT_W'(1);
    end

    // accept is impossible while a word is stalled, so the two branches are exclusive
    if (asm_full_q && slot_free) begin
      out_valid_d = 1'b1;
      rs1_d       = asm_rs1_q;
      rs2_d       = asm_rs2_q;
      mask_d      = asm_mask_q;
      out_last_d  = asm_last_q;
      out_lanes_d = asm_lanes_q;
      asm_full_d  = 1'b0;
    end else if (accept) begin
      if (complete) begin
        lane_idx_d = 2'd0;
        if (slot_free) begin
          out_valid_d = 1'b1;
          rs1_d       = cw_rs1;
          rs2_d       = cw_rs2;
          mask_d      = cw_mask;
          out_last_d  = in_last;
          out_lanes_d = fill_lanes;
        end else begin
          asm_rs1_d   = cw_rs1;
          asm_rs2_d   = cw_rs2;
          asm_mask_d  = cw_mask;
          asm_last_d  = in_last;
          asm_lanes_d = fill_lanes;
          asm_full_d  = 1'b1;
        end
      end else begin
        asm_rs1_d  = wr_rs1;
        asm_rs2_d  = wr_rs2;
        asm_mask_d = wr_mask;
        lane_idx_d = lane_idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx_q   <= 2'd0;
      asm_rs1_q    <= 32'h0;
      asm_rs2_q    <= 32'h0;
      asm_mask_q   <= 32'h0;
      asm_full_q   <= 1'b0;
      asm_last_q   <= 1'b0;
      asm_lanes_q  <= 3'd0;
      out_valid_q  <= 1'b0;
      rs1_q        <= 32'h0;
      rs2_q        <= 32'h0;
      mask_q       <= 32'h0;
      out_last_q   <= 1'b0;
      out_lanes_q  <= 3'd0;
      word_count_q <= '0;
    end else begin
      lane_idx_q   <= lane_idx_d;
      asm_rs1_q    <= asm_rs1_d;
      asm_rs2_q    <= asm_rs2_d;
      asm_mask_q   <= asm_mask_d;
      asm_full_q   <= asm_full_d;
      asm_last_q   <= asm_last_d;
      asm_lanes_q  <= asm_lanes_d;
      out_valid_q  <= out_valid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      mask_q       <= mask_d;
      out_last_q   <= out_last_d;
      out_lanes_q  <= out_lanes_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = !asm_full_q;
  assign out_valid  = out_valid_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign mask       = mask_q;
  assign out_last   = out_last_q;
  assign out_lanes  = out_lanes_q;
  assign word_count = word_count_q;

endmodule
